// File: rtl/restoring_divider16.sv
// Iterative 16-bit unsigned restoring divider: one shift-and-subtract step per clock,
// Start/Done handshake, quotient/remainder/divide-by-zero held in output registers.
module restoring_divider16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [15:0] dividend_i,
   input  logic [15:0] divisor_i,
   output logic [15:0] quotient_o,
   output logic [15:0] remainder_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        div_by_zero_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [16:0] r_q;
   logic [15:0] q_q;
   logic [15:0] d_q;
   logic [4:0]  cnt_q;
   logic [15:0] quotient_q;
   logic [15:0] remainder_q;
   logic        busy_q;
   logic        done_q;
   logic        dbz_q;

   logic [16:0] r_shift_d;
   logic [16:0] t_d;
   logic [16:0] r_step_d;
   logic [15:0] q_step_d;
   logic        no_borrow_d;

   // Trial subtraction in 17-bit two's complement: T = R_shifted - D, so a clear
   // sign bit means the divisor fits and the difference becomes the new remainder.
   always_comb begin
      r_shift_d   = {r_q[15:0], q_q[15]};
      t_d         = r_shift_d + ~{1'b0, d_q} + 17'd1;
      no_borrow_d = ~t_d[16];
      r_step_d    = no_borrow_d ? t_d : r_shift_d;
      q_step_d    = {q_q[14:0], no_borrow_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  d_q   <= divisor_i;
                  q_q   <= dividend_i;
                  r_q   <= '0;
                  cnt_q <= '0;
                  if (divisor_i == 16'd0) begin
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     dbz_q       <= 1'b1;
                     quotient_q  <= 16'hFFFF;
                     remainder_q <= dividend_i;
                  end else begin
                     state_q <= CALC;
                     busy_q  <= 1'b1;
                  end
               end
            end
            CALC: begin
               r_q   <= r_step_d;
               q_q   <= q_step_d;
               cnt_q <= cnt_q + 5'd1;
               // Last iteration: publish the step results directly so Done and data align.
               if (cnt_q == 5'd15) begin
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  dbz_q       <= 1'b0;
                  quotient_q  <= q_step_d;
                  remainder_q <= r_step_d[15:0];
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign quotient_o    = quotient_q;
   assign remainder_o   = remainder_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_restoring_divider16.sv
// Self-checking bench for restoring_divider16: directed cases from the division rules
// plus a randomized sweep checked against plain integer division.
module tb_restoring_divider16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        busy;
   logic        done;
   logic        dbz;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   restoring_divider16 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .dividend_i   (dividend),
      .divisor_i    (divisor),
      .quotient_o   (quotient),
      .remainder_o  (remainder),
      .busy_o       (busy),
      .done_o       (done),
      .div_by_zero_o(dbz)
   );

   function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
      return (b == 16'd0) ? 16'hFFFF : a / b;
   endfunction

   function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
      return (b == 16'd0) ? a : a % b;
   endfunction

   // Called #1 after a rising edge with the DUT idle. lat counts edges after the
   // accept edge until Done is seen; operands are scrambled after acceptance.
   task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int busy_n, output bit got,
                          output logic [15:0] qo, output logic [15:0] ro,
                          output logic dz, output logic busy_at_done,
                          output logic done_after);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      lat      = 0;
      busy_n   = 0;
      while (!done && lat < 40) begin
         if (busy) busy_n++;
         @(posedge clk);
         #1;
         lat++;
      end
      got          = done;
      qo           = quotient;
      ro           = remainder;
      dz           = dbz;
      busy_at_done = busy;
      @(posedge clk);
      #1;
      done_after = done;
      $display("txn %0d / %0d -> q=%0d r=%0d dbz=%0b latency=%0d", a, b, qo, ro, dz, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (quotient !== 16'd0) begin errors++; $display("FAIL reset_quotient: got %h expected 0000", quotient); end
      checks++; if (remainder !== 16'd0) begin errors++; $display("FAIL reset_remainder: got %h expected 0000", remainder); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int lat, bn; bit got; logic [15:0] qo, ro; logic dz, bd, da;
      run_div(16'd100, 16'd7, lat, bn, got, qo, ro, dz, bd, da);
      checks++; if (!got || lat != 16) begin errors++; $display("FAIL basic_latency: got %0d (done=%0b) expected 16", lat, got); end
      checks++; if (bn != 16) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 16", bn); end
      checks++; if (qo !== 16'd14) begin errors++; $display("FAIL basic_quotient: got %0d expected 14", qo); end
      checks++; if (ro !== 16'd2) begin errors++; $display("FAIL basic_remainder: got %0d expected 2", ro); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b expected 0", dz); end
      checks++; if (bd !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", bd); end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL basic_done_width: done still %b one cycle later, expected 0", da); end
   endtask

   task automatic test_edges();
      logic [15:0] ea [5] = '{16'hFFFF, 16'h8000, 16'd5, 16'd0, 16'hFFFF};
      logic [15:0] eb [5] = '{16'h0001, 16'h8000, 16'd9, 16'd1, 16'hFFFF};
      logic [15:0] eq [5] = '{16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd1};
      logic [15:0] er [5] = '{16'd0, 16'd0, 16'd5, 16'd0, 16'd0};
      int lat, bn; bit got; logic [15:0] qo, ro; logic dz, bd, da;
      for (int i = 0; i < 5; i++) begin
         run_div(ea[i], eb[i], lat, bn, got, qo, ro, dz, bd, da);
         checks++; if (!got || lat != 16) begin errors++; $display("FAIL edge%0d_latency: got %0d expected 16", i, lat); end
         checks++; if (qo !== eq[i]) begin errors++; $display("FAIL edge%0d_quotient: got %h expected %h", i, qo, eq[i]); end
         checks++; if (ro !== er[i]) begin errors++; $display("FAIL edge%0d_remainder: got %h expected %h", i, ro, er[i]); end
         checks++; if (dz !== 1'b0) begin errors++; $display("FAIL edge%0d_dbz: got %b expected 0", i, dz); end
      end
   endtask

   task automatic test_div_zero();
      int lat, bn; bit got; logic [15:0] qo, ro; logic dz, bd, da;
      run_div(16'h1234, 16'd0, lat, bn, got, qo, ro, dz, bd, da);
      checks++; if (!got || lat != 0) begin errors++; $display("FAIL dbz_latency: got %0d edges after accept expected 0", lat); end
      checks++; if (bn != 0 || bd !== 1'b0) begin errors++; $display("FAIL dbz_busy: got %0d busy cycles expected 0", bn); end
      checks++; if (qo !== 16'hFFFF) begin errors++; $display("FAIL dbz_quotient: got %h expected ffff", qo); end
      checks++; if (ro !== 16'h1234) begin errors++; $display("FAIL dbz_remainder: got %h expected 1234", ro); end
      checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", dz); end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL dbz_done_width: got %b expected 0", da); end
      run_div(16'd9, 16'd3, lat, bn, got, qo, ro, dz, bd, da);
      checks++; if (!got || qo !== 16'd3 || ro !== 16'd0) begin errors++; $display("FAIL after_dbz_result: got q=%0d r=%0d expected q=3 r=0", qo, ro); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL after_dbz_flag: got %b expected 0", dz); end
   endtask

   task automatic test_ignore_start();
      int cycles, ndone, nbusy;
      dividend = 16'd50;
      divisor  = 16'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 16'd60;
      divisor  = 16'd7;
      cycles   = 0;
      repeat (4) begin @(posedge clk); #1; cycles++; end
      start = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
      start = 1'b0;
      while (!done && cycles < 40) begin @(posedge clk); #1; cycles++; end
      $display("txn 50 / 5 (start re-pulsed mid-calc) -> q=%0d r=%0d latency=%0d", quotient, remainder, cycles);
      checks++; if (!done || cycles != 16) begin errors++; $display("FAIL ignore_latency: got %0d expected 16", cycles); end
      checks++; if (quotient !== 16'd10 || remainder !== 16'd0) begin errors++; $display("FAIL ignore_result: got q=%0d r=%0d expected q=10 r=0", quotient, remainder); end
      ndone = 0;
      nbusy = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
         if (busy) nbusy++;
      end
      checks++; if (ndone != 0 || nbusy != 0) begin errors++; $display("FAIL ignore_no_second_op: got done=%0d busy=%0d cycles expected 0", ndone, nbusy); end
   endtask

   task automatic test_async_reset();
      int lat, bn, ndone, nbusy; bit got; logic [15:0] qo, ro; logic dz, bd, da;
      run_div(16'd77, 16'd10, lat, bn, got, qo, ro, dz, bd, da);
      checks++; if (qo !== 16'd7 || ro !== 16'd7) begin errors++; $display("FAIL pre_reset_result: got q=%0d r=%0d expected q=7 r=7", qo, ro); end
      dividend = 16'd500;
      divisor  = 16'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      $display("txn 500 / 3 aborted by reset mid-calc");
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
      checks++; if (quotient !== 16'd0 || remainder !== 16'd0) begin errors++; $display("FAIL async_reset_outputs: got q=%0d r=%0d expected 0 0", quotient, remainder); end
      checks++; if (done !== 1'b0 || dbz !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got done=%b dbz=%b expected 0 0", done, dbz); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ndone = 0;
      nbusy = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
         if (busy) nbusy++;
      end
      checks++; if (ndone != 0 || nbusy != 0) begin errors++; $display("FAIL async_reset_no_done: got done=%0d busy=%0d cycles expected 0", ndone, nbusy); end
      run_div(16'd1000, 16'd33, lat, bn, got, qo, ro, dz, bd, da);
      checks++; if (!got || qo !== 16'd30 || ro !== 16'd10) begin errors++; $display("FAIL post_reset_result: got q=%0d r=%0d expected q=30 r=10", qo, ro); end
   endtask

   task automatic test_random();
      int lat, bn; bit got; logic [15:0] qo, ro; logic dz, bd, da;
      logic [15:0] a, b;
      for (int n = 0; n < 2000; n++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
         run_div(a, b, lat, bn, got, qo, ro, dz, bd, da);
         checks++; if (!got || lat != 16) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 16", n, lat); end
         checks++; if (qo !== ref_q(a, b) || ro !== ref_r(a, b)) begin errors++; $display("FAIL rand%0d_result: %0d/%0d got q=%0d r=%0d expected q=%0d r=%0d", n, a, b, qo, ro, ref_q(a, b), ref_r(a, b)); end
         checks++; if ((32'(qo) * 32'(b) + 32'(ro)) != 32'(a) || ro >= b) begin errors++; $display("FAIL rand%0d_identity: %0d/%0d got q=%0d r=%0d", n, a, b, qo, ro); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edges();
      test_div_zero();
      test_ignore_start();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
